// File: rtl/frame_transmit_if.sv
// Host/line signal bundle for the framed serial transmitter.
// The master side is the host; the slave side is the transmitter itself.
interface frame_transmit_if;
  logic [7:0] baudrate;
  logic       txfifowrite;
  logic [7:0] datain;
  logic       TX;
  logic       busy;
  logic       full;
  logic       empty;
  logic       over;

  modport master (
    output baudrate, txfifowrite, datain,
    input  TX, busy, full, empty, over
  );

  modport slave (
    input  baudrate, txfifowrite, datain,
    output TX, busy, full, empty, over
  );
endinterface

// File: rtl/frame_transmit.sv
// Framed serial transmitter: TX FIFO plus serialiser emitting
// start, 4-bit size, N data bytes, CRC-8, stop -- one bit per baud period.

module crc #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       enable,
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out
);
  // Synchronous clear; the transmitter holds it asserted while idle.
  always_ff @(posedge clk) begin
    if (reset)
      out <= '0;
    else if (enable)
      out <= {out[6:0], 1'b0} ^ ((out[7] ^ in) ? POLY : '0);
  end
endmodule

module frame_transmit #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  CRC_POLY   = 8'h07
) (
  input logic              clk,
  input logic              rst_n,
  frame_transmit_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRC, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, over, wr, pop;
  logic [3:0]    n_avail;

  state_t     state;
  logic [7:0] cnt, baud_l, shreg, head, crc_out;
  logic [3:0] nsize, bytes_left;
  logic [2:0] bitidx, nxt;
  logic       tx, busy, tick, crc_en, crc_in, crc_clr;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr      = bus.txfifowrite && !full;
  assign n_avail = (count > (AW+1)'(15)) ? 4'd15 : 4'(count);
  assign head    = mem[rptr];
  assign tick    = (cnt == baud_l);
  assign nxt     = bitidx - 3'd1;
  assign crc_clr = (state == IDLE);

  assign bus.TX    = tx;
  assign bus.busy  = busy;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.over  = over;

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= bus.datain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      over  <= 1'b0;
    end else begin
      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (bus.txfifowrite && full)
        over <= 1'b1;
    end
  end

  // The CRC is fed on the cycle a size/data bit is launched, so the register
  // already holds the final value when the CRC field begins.
  always_comb begin
    pop    = 1'b0;
    crc_en = 1'b0;
    crc_in = 1'b0;
    if (tick) begin
      case (state)
        START: begin
          crc_en = 1'b1;
          crc_in = nsize[3];
        end
        SIZE: begin
          crc_en = 1'b1;
          if (bitidx == 3'd0) begin
            pop    = 1'b1;
            crc_in = head[7];
          end else begin
            crc_in = nsize[nxt[1:0]];
          end
        end
        DATA: begin
          if (bitidx != 3'd0) begin
            crc_en = 1'b1;
            crc_in = shreg[nxt];
          end else if (bytes_left != 4'd0) begin
            pop    = 1'b1;
            crc_en = 1'b1;
            crc_in = head[7];
          end
        end
        default: ;
      endcase
    end
  end

  crc #(.POLY(CRC_POLY)) u_crc (
    .enable (crc_en),
    .clk    (clk),
    .reset  (crc_clr),
    .in     (crc_in),
    .out    (crc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      baud_l     <= '0;
      nsize      <= '0;
      bytes_left <= '0;
      bitidx     <= '0;
      shreg      <= '0;
      tx         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (state != IDLE)
        cnt <= tick ? '0 : cnt + 8'd1;
      case (state)
        IDLE: begin
          tx <= 1'b0;
          if (!empty) begin
            state      <= START;
            tx         <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            baud_l     <= bus.baudrate;
            nsize      <= n_avail;
            bytes_left <= n_avail;
          end
        end
        START: if (tick) begin
          state  <= SIZE;
          tx     <= nsize[3];
          bitidx <= 3'd3;
        end
        SIZE: if (tick) begin
          if (bitidx == 3'd0) begin
            state      <= DATA;
            tx         <= head[7];
            shreg      <= head;
            bitidx     <= 3'd7;
            bytes_left <= bytes_left - 4'd1;
          end else begin
            tx     <= nsize[nxt[1:0]];
            bitidx <= nxt;
          end
        end
        DATA: if (tick) begin
          if (bitidx != 3'd0) begin
            tx     <= shreg[nxt];
            bitidx <= nxt;
          end else if (bytes_left == 4'd0) begin
            state  <= CRC;
            tx     <= crc_out[7];
            bitidx <= 3'd7;
          end else begin
            tx         <= head[7];
            shreg      <= head;
            bitidx     <= 3'd7;
            bytes_left <= bytes_left - 4'd1;
          end
        end
        CRC: if (tick) begin
          if (bitidx == 3'd0) begin
            state <= STOP;
            tx    <= 1'b0;
          end else begin
            tx     <= crc_out[nxt];
            bitidx <= nxt;
          end
        end
        STOP: if (tick) begin
          state <= IDLE;
          tx    <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_transmit.sv
// Directed/randomized bench for frame_transmit: a queue-based FIFO model
// predicts every frame's bit stream, which is checked clock by clock on TX.
module tb_frame_transmit;
  logic clk = 1'b0;
  logic rst_n;

  frame_transmit_if bus ();

  frame_transmit #(.FIFO_DEPTH(16), .CRC_POLY(8'h07)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [7:0]  q[$];
  logic [7:0]  pend[$];
  logic        over_m;
  int          baud_set;
  logic [7:0]  crc_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Call at a negedge; returns at the following negedge after the push landed.
  task automatic write_byte(input logic [7:0] d);
    bus.datain      = d;
    bus.txfifowrite = 1'b1;
    @(negedge clk);
    bus.txfifowrite = 1'b0;
    if (q.size() == 16) over_m = 1'b1;
    else q.push_back(d);
    chk("wr_full",  {31'b0, bus.full},  {31'b0, q.size() == 16});
    chk("wr_empty", {31'b0, bus.empty}, {31'b0, q.size() == 0});
    chk("wr_over",  {31'b0, bus.over},  {31'b0, over_m});
  endtask

  // Once the running frame has taken its last byte, enqueue pend and change baudrate.
  task automatic tail(input int nb);
    int n = 0;
    while (!(bus.empty === 1'b1 && bus.busy === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("tail_empty_while_busy", {31'b0, n < 20000}, 32'd1);
    if (n >= 20000) return;
    while (pend.size() > 0) write_byte(pend.pop_front());
    bus.baudrate = nb[7:0];
    baud_set     = nb;
  endtask

  task automatic run_frame(input int exp_gap, output logic [7:0] cobs);
    int gap = 0;
    int n, b, last;
    logic exp_bits[$];
    logic [7:0] c, by;
    logic fb, ok, bad_tx, bad_busy;
    cobs = '0;
    @(negedge clk);
    while (bus.busy !== 1'b1 && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    chk("frame_start", {31'b0, gap < 50}, 32'd1);
    if (gap >= 50) return;
    if (exp_gap >= 0) chk("idle_gap", gap, exp_gap);
    b = baud_set;
    n = (q.size() > 15) ? 15 : q.size();
    exp_bits.push_back(1'b1);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(n[i]);
    for (int k = 0; k < n; k++) begin
      by = q.pop_front();
      for (int i = 7; i >= 0; i--) exp_bits.push_back(by[i]);
    end
    c = 8'h00;
    for (int i = 1; i < exp_bits.size(); i++) begin
      fb = c[7] ^ exp_bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    for (int i = 7; i >= 0; i--) exp_bits.push_back(c[i]);
    exp_bits.push_back(1'b0);
    last = exp_bits.size() - 1;
    for (int i = 0; i <= last; i++) begin
      ok = 1'b1;
      bad_tx = 1'b0;
      bad_busy = 1'b0;
      for (int j = 0; j <= b; j++) begin
        if (!(i == 0 && j == 0)) @(negedge clk);
        if (bus.TX !== exp_bits[i] || bus.busy !== 1'b1) begin
          ok = 1'b0;
          bad_tx = bus.TX;
          bad_busy = bus.busy;
        end
        if (j == 0 && i >= last - 8 && i < last) cobs = {cobs[6:0], bus.TX};
      end
      checks++;
      assert (ok) passed++;
      else $error("FAIL frame_bit%0d (N=%0d baud=%0d): TX=%b busy=%b expected TX=%b busy=1",
                  i, n, b, bad_tx, bad_busy, exp_bits[i]);
    end
    @(negedge clk);
    chk("after_stop_tx",   {31'b0, bus.TX},   32'd0);
    chk("after_stop_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic ok;
    int n;
    rst_n           = 1'b0;
    bus.txfifowrite = 1'b0;
    bus.datain      = 8'h00;
    bus.baudrate    = 8'd3;
    baud_set        = 3;
    over_m          = 1'b0;
    #22;
    chk("rst_tx",    {31'b0, bus.TX},    32'd0);
    chk("rst_busy",  {31'b0, bus.busy},  32'd0);
    chk("rst_full",  {31'b0, bus.full},  32'd0);
    chk("rst_empty", {31'b0, bus.empty}, 32'd1);
    chk("rst_over",  {31'b0, bus.over},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single A5 byte at 4 clocks/bit; 01 02 03 queued during its tail
    write_byte(8'hA5);
    pend = '{8'h01, 8'h02, 8'h03};
    fork
      run_frame(-1, crc_obs);
      tail(0);
    join
    chk("a5_crc", {24'b0, crc_obs}, 32'h67);

    // Three-byte frame at 1 clock/bit; baudrate goes to 255 mid-frame
    pend = '{8'($urandom_range(0, 255))};
    fork
      run_frame(0, crc_obs);
      tail(255);
    join

    // Slow single-byte frame, 17 writes during it: 16 kept, 17th dropped
    for (int i = 0; i < 17; i++) pend.push_back(8'($urandom_range(0, 255)));
    fork
      run_frame(0, crc_obs);
      tail(1);
    join
    run_frame(0, crc_obs);

    // Leftover single byte; a write lands during its DATA phase
    pend = '{8'($urandom_range(0, 255))};
    fork
      run_frame(0, crc_obs);
      tail(3);
    join

    // baudrate 3 -> 7 mid-frame: this frame stays at 4 clocks/bit, next at 8
    pend = '{8'($urandom_range(0, 255))};
    fork
      run_frame(0, crc_obs);
      tail(7);
    join
    run_frame(0, crc_obs);

    // Randomised chained frames
    bus.baudrate = 8'($urandom_range(0, 3));
    baud_set     = int'(bus.baudrate);
    write_byte(8'($urandom_range(0, 255)));
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) pend.push_back(8'($urandom_range(0, 255)));
      fork
        run_frame((r == 0) ? -1 : 0, crc_obs);
        if (r < 4) tail($urandom_range(0, 3));
      join
      pend.delete();
    end

    // Reset in the middle of the DATA field
    bus.baudrate = 8'd2;
    baud_set     = 2;
    write_byte(8'h3C);
    n = 0;
    while (!(bus.empty === 1'b1 && bus.busy === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_in_data", {31'b0, n < 200}, 32'd1);
    chk("pre_rst_over_sticky", {31'b0, bus.over}, {31'b0, over_m});
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx",    {31'b0, bus.TX},    32'd0);
    chk("midrst_busy",  {31'b0, bus.busy},  32'd0);
    chk("midrst_empty", {31'b0, bus.empty}, 32'd1);
    chk("midrst_full",  {31'b0, bus.full},  32'd0);
    chk("midrst_over",  {31'b0, bus.over},  32'd0);
    q.delete();
    over_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.TX !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    assert (ok) passed++;
    else $error("FAIL post_reset_idle: TX=%b busy=%b expected TX=0 busy=0", bus.TX, bus.busy);
    chk("post_reset_empty", {31'b0, bus.empty}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/frame_transmit.md
Name: frame_transmit

Overview:
- Transmit end of the framed serial link; mirror image of the frame receiver.
- Buffers bytes written by the host in a 16-entry TX FIFO and serialises them onto TX as frames.
- Frame format, one bit per baud period: start bit, 4-bit frame size, N data bytes, 8-bit CRC, stop bit.
- Sits between the host write port and the physical line.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries (power of two; pointers are log2(FIFO_DEPTH) bits, occupancy count one bit wider)
CRC_POLY, 8'h07, CRC-8 generator polynomial; must equal the polynomial of the shared crc module

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
baudrate  in  8  bit period minus one, in clk cycles (bit lasts baudrate+1 clocks)
txfifowrite  in  1  push datain into TX FIFO this cycle
datain  in  8  byte to enqueue
TX  out  1  serial line; idles low
busy  out  1  high from first cycle of start bit through last cycle of stop bit
full  out  1  FIFO holds FIFO_DEPTH bytes
empty  out  1  FIFO holds 0 bytes
over  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (async, rst_n low): TX=0, busy=0, full=0, empty=1, over=0. FIFO pointers and count=0, state=IDLE, baud counter=0, CRC register=0.
- Reset mid-frame aborts the frame immediately: TX=0 and FIFO contents are discarded.
- Bit timing:
  - Baud counter runs 0..baudrate while not IDLE.
  - Each bit holds TX for exactly baudrate+1 clocks.
  - Next bit is presented on the cycle after counter==baudrate.
  - baudrate is sampled only at frame start; changes mid-frame are ignored.
- FIFO write:
  - txfifowrite && !full: store datain, count+1.
  - txfifowrite && full: data dropped, over<=1 (sticky until reset).
  - Simultaneous write and pop: both take effect, count unchanged. A write while full coincident with a pop is still dropped, because full is evaluated before the pop.
- States:
  - IDLE: TX=0. When !empty, latch N=min(count,15), clear CRC, enter START on the next clock. busy rises with the START bit.
  - START: TX=1 for one bit period.
  - SIZE: send N[3:0] MSB first, 4 bits. Each bit is fed into the CRC as it is sent.
  - DATA: pop the FIFO head at the start of each byte and send bits [7]..[0]. Each bit is fed into the CRC. Repeat for N bytes.
    - N is fixed at frame start; bytes written during the frame go to a later frame.
  - CRC: send the CRC register bits [7]..[0]. The register is frozen during this state.
  - STOP: TX=0 for one bit period; then IDLE with busy=0.
    - If the FIFO is non-empty, the next START begins after one idle clock.
- CRC:
  - Bit-serial, init 8'h00, no reflection, no final XOR.
  - Per bit: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?CRC_POLY:0).
  - Covers the 4 size bits and all data bits.
  - Implemented by instancing the existing crc module (enable, clk, reset, in, out); enable pulses once per transmitted size/data bit.
- Frame length: 1+4+8N+8+1 bits = (22+8(N-1))*(baudrate+1) clocks.
- baudrate=0 is legal: one clock per bit.
- Count 16 sends a 15-byte frame first, then a 1-byte frame.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- baudrate=3, write 8'hA5 once -> busy high 88 clocks. TX bit sequence 1,0001,10100101,01100111(CRC 8'h67),0, each bit held 4 clocks. empty=1 after the data byte pops; busy=0 after stop.
- baudrate=0, write 8'h01,8'h02,8'h03 back-to-back -> a single frame with size 0011, data 01 02 03 MSB first, CRC per formula. Frame length 38 clocks.
- 17 writes with no drain (baudrate=255, writes land before the first pop) -> full after 16, over=1, 17th byte absent. A 15-byte frame is followed by a 1-byte frame.
- Write during DATA of an N=1 frame -> current frame size stays 0001; new byte goes out in the next frame after one idle clock.
- Assert rst_n low mid-DATA -> TX=0, busy=0, empty=1, over=0 asynchronously. Post-release TX idles low with no residual frame.
- Change baudrate from 3 to 7 mid-frame -> remaining bits still 4 clocks each; the next frame uses 8 clocks per bit.
